// File: rtl/mac_result_quantizer.sv
// mac_result_quantizer: ReLU, round-shift and saturate the final MAC sum
// of each dot product, then queue the activations in a small FIFO.
module mac_result_quantizer #(
  parameter int IN_W    = 28,
  parameter int OUT_W   = 14,
  parameter int SHIFT   = 8,
  parameter int VEC_LEN = 4,
  parameter int DEPTH   = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic signed [IN_W-1:0]  f_in,
  input  logic                    valid_in,
  input  logic                    clr,
  output logic signed [OUT_W-1:0] out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    overflow
);

  localparam int CW  = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
  localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNW = $clog2(DEPTH + 1);
  localparam int SW  = IN_W + 1;

  localparam logic [CW-1:0]  CLAST = CW'(VEC_LEN - 1);
  localparam logic [SW-1:0]  HALF  = SW'(1) << (SHIFT - 1);
  localparam logic [SW-1:0]  SATV  = SW'((1 << (OUT_W - 1)) - 1);
  localparam logic [CNW-1:0] FULL  = CNW'(DEPTH);

  logic [CW-1:0]    cnt;
  logic             fin;
  logic [IN_W-1:0]  x;
  logic [SW-1:0]    sum;
  logic [SW-1:0]    y;
  logic             s1_v;
  logic [SW-1:0]    s1_y;
  logic             s2_v;
  logic [OUT_W-1:0] s2_z;
  logic [OUT_W-1:0] z;

  logic [OUT_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [CNW-1:0]   count;
  logic             push;
  logic             pop;
  logic             acc;

  function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign fin = valid_in && !clr && (cnt == CLAST);
  assign x   = f_in[IN_W-1] ? '0 : f_in;
  assign sum = {1'b0, x} + HALF;
  assign y   = sum >> SHIFT;
  assign z   = (s1_y > SATV) ? OUT_W'(SATV) : s1_y[OUT_W-1:0];

  assign pop       = out_valid && out_ready;
  assign push      = s2_v;
  assign acc       = push && ((count < FULL) || pop);
  assign out_valid = (count != '0);
  assign out_data  = mem[rptr];

  // beat counter marking the last valid beat of each dot product
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cnt <= '0;
    else if (clr)
      cnt <= '0;
    else if (valid_in)
      cnt <= (cnt == CLAST) ? '0 : cnt + CW'(1);
  end

  // stage 1: relu plus round-half-up shift of the final sum
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_v <= 1'b0;
      s1_y <= '0;
    end else begin
      s1_v <= fin;
      if (fin)
        s1_y <= y;
    end
  end

  // stage 2: clamp to the largest positive activation
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_v <= 1'b0;
      s2_z <= '0;
    end else begin
      s2_v <= s1_v;
      if (s1_v)
        s2_z <= z;
    end
  end

  // result fifo with sticky drop flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (acc) begin
        mem[wptr] <= s2_z;
        wptr      <= inc(wptr);
      end
      if (pop)
        rptr <= inc(rptr);
      if (acc && !pop)
        count <= count + CNW'(1);
      else if (!acc && pop)
        count <= count - CNW'(1);
      if (clr)
        overflow <= 1'b0;
      else if (push && !acc)
        overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mac_result_quantizer.sv
// tb_mac_result_quantizer: directed vectors for the quantizer
// with hand-computed activations.
module tb_mac_result_quantizer;

  logic               clk = 1'b0;
  logic               reset;
  logic signed [27:0] f_in;
  logic               valid_in;
  logic               clr;
  logic signed [13:0] out_data;
  logic               out_valid;
  logic               out_ready;
  logic               overflow;

  int n_chk  = 0;
  int n_fail = 0;
  int got[$];

  mac_result_quantizer dut (
    .clk       (clk),
    .reset     (reset),
    .f_in      (f_in),
    .valid_in  (valid_in),
    .clr       (clr),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (out_valid && out_ready)
      got.push_back(int'(out_data));

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++)
      tick();
  endtask

  task automatic send_vec(input logic signed [27:0] a,
                          input logic signed [27:0] b,
                          input logic signed [27:0] c,
                          input logic signed [27:0] d,
                          input bit gap);
    logic signed [27:0] v [4];
    v = '{a, b, c, d};
    for (int i = 0; i < 4; i++) begin
      valid_in = 1'b1;
      f_in     = v[i];
      tick();
      if (gap) begin
        valid_in = 1'b0;
        f_in     = 28'sd999;
        tick();
      end
    end
    valid_in = 1'b0;
    f_in     = '0;
  endtask

  task automatic chk_got(input string tag, input int exp[$]);
    chk({tag, "_n"}, got.size(), exp.size());
    for (int i = 0; i < exp.size(); i++)
      chk($sformatf("%s_%0d", tag, i),
          (i < got.size()) ? got[i] : -1, exp[i]);
  endtask

  initial begin
    reset     = 1'b1;
    f_in      = '0;
    valid_in  = 1'b0;
    clr       = 1'b0;
    out_ready = 1'b0;
    #1;
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_ovf", int'(overflow), 0);
    chk("rst_data", int'(out_data), 0);
    tick();
    reset = 1'b0;
    tick();

    // basic latency
    out_ready = 1'b1;
    got.delete();
    valid_in = 1'b1;
    f_in = 28'sd100;
    tick();
    chk("lat_b1", int'(out_valid), 0);
    f_in = 28'sd200;
    tick();
    chk("lat_b2", int'(out_valid), 0);
    f_in = 28'sd300;
    tick();
    chk("lat_b3", int'(out_valid), 0);
    f_in = 28'sd1000;
    tick();
    valid_in = 1'b0;
    f_in = '0;
    chk("lat_e0", int'(out_valid), 0);
    tick();
    chk("lat_e1", int'(out_valid), 0);
    tick();
    chk("lat_e2", int'(out_valid), 1);
    chk("lat_data", int'(out_data), 4);
    tick();
    chk("lat_e3", int'(out_valid), 0);
    ticks(3);
    chk_got("lat", '{4});

    // relu and rounding, with gaps between beats
    got.delete();
    send_vec(7, 7, 7, -28'sd5000, 1'b1);
    send_vec(7, 7, 7, 28'sd383, 1'b1);
    send_vec(7, 7, 7, 28'sd384, 1'b0);
    send_vec(7, 7, 7, 28'sd127, 1'b1);
    ticks(5);
    chk_got("relu", '{0, 1, 2, 0});

    // saturation
    got.delete();
    send_vec(0, 0, 0, 28'sd134217727, 1'b0);
    send_vec(0, 0, 0, -28'sd134217728, 1'b0);
    ticks(5);
    chk_got("sat", '{8191, 0});

    // backpressure and overflow
    got.delete();
    out_ready = 1'b0;
    for (int k = 1; k <= 5; k++)
      send_vec(0, 0, 0, 28'(256 * k), 1'b0);
    ticks(4);
    chk("bp_ovf", int'(overflow), 1);
    chk("bp_valid", int'(out_valid), 1);
    chk("bp_head", int'(out_data), 1);
    chk("bp_none", got.size(), 0);
    out_ready = 1'b1;
    ticks(4);
    chk("bp_empty", int'(out_valid), 0);
    chk("bp_ovf_hold", int'(overflow), 1);
    chk_got("bp", '{1, 2, 3, 4});
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("bp_ovf_clr", int'(overflow), 0);

    // full fifo with push and pop on the same edge
    got.delete();
    out_ready = 1'b0;
    for (int k = 1; k <= 4; k++)
      send_vec(0, 0, 0, 28'(256 * k), 1'b0);
    ticks(2);
    chk("full_valid", int'(out_valid), 1);
    chk("full_ovf0", int'(overflow), 0);
    send_vec(0, 0, 0, 28'sd2304, 1'b0);
    tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("full_ovf1", int'(overflow), 0);
    chk("full_head", int'(out_data), 2);
    out_ready = 1'b1;
    ticks(4);
    chk("full_empty", int'(out_valid), 0);
    chk_got("full", '{1, 2, 3, 4, 9});

    // clr mid-vector keeps queued data and restarts counting
    got.delete();
    out_ready = 1'b0;
    send_vec(0, 0, 0, 28'sd1792, 1'b0);
    ticks(3);
    valid_in = 1'b1;
    f_in = 28'sd5000;
    ticks(2);
    clr = 1'b1;
    f_in = 28'sd9999;
    tick();
    clr = 1'b0;
    send_vec(0, 0, 0, 28'sd768, 1'b0);
    ticks(3);
    out_ready = 1'b1;
    ticks(6);
    chk_got("clr", '{7, 3});

    // asynchronous reset with queued and in-flight results
    got.delete();
    out_ready = 1'b0;
    send_vec(0, 0, 0, 28'sd1280, 1'b0);
    send_vec(0, 0, 0, 28'sd1536, 1'b0);
    ticks(2);
    chk("ar_valid_pre", int'(out_valid), 1);
    send_vec(0, 0, 0, 28'sd2048, 1'b0);
    #1;
    reset = 1'b1;
    #1;
    chk("ar_valid", int'(out_valid), 0);
    chk("ar_data", int'(out_data), 0);
    tick();
    reset = 1'b0;
    out_ready = 1'b1;
    ticks(6);
    chk("ar_after", int'(out_valid), 0);
    chk_got("ar", '{});

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
